// File: rtl/lc3_mem_access_if.sv
// Data-memory port between the LC3 memory-access stage (master) and data memory (slave).
// dmem_req is held with dmem_addr/dmem_we/dmem_wdata stable until a cycle where dmem_req and
// dmem_ready are both high, which completes the transfer; dmem_ready without dmem_req is ignored.
interface lc3_mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ready;
  logic [15:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/lc3_mem_access.sv
// LC3 data-memory access stage: runs READ / IND_READ / WRITE commands from the pipeline
// controller on a req/ready memory port, with a per-request wait-cycle timeout.
module lc3_mem_access #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           mem_state,
  input  logic [15:0]          M_Addr,
  input  logic [15:0]          M_Data,
  lc3_mem_access_if.master     dmem,
  output logic [15:0]          memout,
  output logic                 complete_data,
  output logic                 mem_error,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_IND1 = 3'd2;
  localparam logic [2:0] S_IND2 = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_IND   = 2'b01;
  localparam logic [1:0] CMD_IDLE  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             armed;
  logic             ind_gap;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      addr_q;
  logic [15:0]      data_q;

  logic busy;
  logic req;
  logic accept;
  logic hit;
  logic tmo;

  assign busy   = (state == S_RD) || (state == S_IND1) || (state == S_IND2) || (state == S_WR);
  // The first IND2 cycle is a bubble so the pointer fetch and the data fetch are separate requests.
  assign req    = busy && !ind_gap;
  assign accept = (state == S_IDLE) && armed && (mem_state != CMD_IDLE);
  assign hit    = req && dmem.dmem_ready;
  // The counter holds the number of wait cycles already seen, so this is the TIMEOUT-th one.
  assign tmo    = req && !dmem.dmem_ready && (wait_cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (mem_state == CMD_READ)     state_nx = S_RD;
          else if (mem_state == CMD_IND) state_nx = S_IND1;
          else                           state_nx = S_WR;
        end
      end
      S_RD, S_IND2, S_WR: begin
        if (hit || tmo) state_nx = S_DONE;
      end
      S_IND1: begin
        if (hit)      state_nx = S_IND2;
        else if (tmo) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      armed     <= 1'b1;
      ind_gap   <= 1'b0;
      wait_cnt  <= '0;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      memout    <= 16'h0000;
      mem_error <= 1'b0;
    end else begin
      state   <= state_nx;
      ind_gap <= (state == S_IND1) && hit;

      // A command is executed once; seeing IDLE on mem_state is what allows the next one.
      if (mem_state == CMD_IDLE) armed <= 1'b1;
      else if (accept)           armed <= 1'b0;

      if (state_nx != state)     wait_cnt <= '0;
      else if (req && !dmem.dmem_ready) wait_cnt <= wait_cnt + CNT_ONE;

      if (accept) begin
        addr_q <= M_Addr;
        data_q <= M_Data;
      end else if ((state == S_IND1) && hit) begin
        addr_q <= dmem.dmem_rdata;
      end

      if (hit && ((state == S_RD) || (state == S_IND2))) memout <= dmem.dmem_rdata;
      if (tmo) mem_error <= 1'b1;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = (state == S_WR);
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = data_q;
  assign complete_data   = (state == S_DONE);
  assign dbg_state       = state;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Self-checking bench for lc3_mem_access: planned memory latencies, transaction-level expected
// waveform queue compared every cycle, plus literal checks on the directed scenarios.
module tb_lc3_mem_access;
  localparam int TMO = 4;
  localparam int W   = 53;

  logic        clock;
  logic        reset_n;
  logic [1:0]  mem_state;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic [15:0] memout;
  logic        complete_data;
  logic        mem_error;
  logic [2:0]  dbg_state;

  lc3_mem_access_if dmem_bus ();

  lc3_mem_access #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mem_state     (mem_state),
    .M_Addr        (M_Addr),
    .M_Data        (M_Data),
    .dmem          (dmem_bus),
    .memout        (memout),
    .complete_data (complete_data),
    .mem_error     (mem_error),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // exp layout: [52]=check bus, [51]=req, [50]=we, [49:34]=addr, [33:18]=wdata,
  //             [17]=complete, [16]=mem_error, [15:0]=memout
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cmp_e;
  int n_cmp = 0;
  int n_err = 0;
  int req_cycles = 0;
  int cpl_cnt = 0;

  logic [15:0] m_memout;
  logic        m_err;

  function automatic logic [W-1:0] mk(input logic chk, input logic req, input logic we,
                                      input logic [15:0] a, input logic [15:0] wd,
                                      input logic cpl, input logic err, input logic [15:0] mo);
    return {chk, req, we, a, wd, cpl, err, mo};
  endfunction

  function automatic logic [W-1:0] idle_e();
    return mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, m_err, m_memout);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chk("req",      16'(dmem_bus.dmem_req), 16'(cmp_e[51]));
      chk("complete", 16'(complete_data),     16'(cmp_e[17]));
      chk("mem_error",16'(mem_error),         16'(cmp_e[16]));
      chk("memout",   memout,                 cmp_e[15:0]);
      if (cmp_e[52]) begin
        chk("we",   16'(dmem_bus.dmem_we), 16'(cmp_e[50]));
        chk("addr", dmem_bus.dmem_addr,    cmp_e[49:34]);
        if (cmp_e[50]) chk("wdata", dmem_bus.dmem_wdata, cmp_e[33:18]);
      end
    end
    if (dmem_bus.dmem_req) req_cycles++;
    if (complete_data) cpl_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rst, input logic [1:0] ms, input logic [15:0] a, input logic [15:0] d,
                     input logic rdy, input logic [15:0] rd, input logic [W-1:0] e);
    @(posedge clock);
    #1;
    reset_n             = rst;
    mem_state           = ms;
    M_Addr              = a;
    M_Data              = d;
    dmem_bus.dmem_ready = rdy;
    dmem_bus.dmem_rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic idle_cyc(input logic [1:0] ms);
    cyc(1'b1, ms, 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), idle_e());
  endtask

  task automatic busy_junk(input logic [W-1:0] e);
    cyc(1'b1, 2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 1'($urandom),
        16'($urandom), e);
  endtask

  // One request: l wait cycles before ready; l >= TMO means the memory never answers in time.
  task automatic phase(input logic [15:0] pa, input logic pwe, input logic [15:0] pwd,
                       input int l, input logic [15:0] rd, output logic ok);
    int   n;
    logic rdy;
    n = (l < TMO) ? l + 1 : TMO;
    for (int i = 0; i < n; i++) begin
      rdy = (l < TMO) && (i == l);
      cyc(1'b1, 2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), rdy,
          rdy ? rd : 16'($urandom), mk(1'b1, 1'b1, pwe, pa, pwd, 1'b0, m_err, m_memout));
    end
    ok = (l < TMO);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                         input int l1, input int l2, input logic [15:0] r1, input logic [15:0] r2,
                         input int n_pre, input int n_hold);
    logic ok;
    logic ok2;
    for (int i = 0; i < n_pre; i++) idle_cyc(2'b11);
    cyc(1'b1, op, a, d, 1'($urandom), 16'($urandom), idle_e());
    case (op)
      2'b00: begin
        phase(a, 1'b0, 16'h0, l1, r1, ok);
        if (ok) m_memout = r1; else m_err = 1'b1;
      end
      2'b01: begin
        phase(a, 1'b0, 16'h0, l1, r1, ok);
        if (ok) begin
          busy_junk(idle_e());
          phase(r1, 1'b0, 16'h0, l2, r2, ok2);
          if (ok2) m_memout = r2; else m_err = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      default: begin
        phase(a, 1'b1, d, l1, r1, ok);
        if (!ok) m_err = 1'b1;
      end
    endcase
    busy_junk(mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, m_err, m_memout));
    for (int i = 0; i < n_hold; i++) idle_cyc(op);
  endtask

  task automatic clr_cnt();
    req_cycles = 0;
    cpl_cnt    = 0;
  endtask

  // ---------------- main sequence ----------------
  logic ok_tmp;

  initial begin
    reset_n             = 1'b0;
    mem_state           = 2'b11;
    M_Addr              = 16'h0;
    M_Data              = 16'h0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 16'h0;
    m_memout            = 16'h0;
    m_err               = 1'b0;

    cyc(1'b0, 2'b11, 16'h0, 16'h0, 1'b0, 16'h0, mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0));
    cyc(1'b0, 2'b00, 16'h1234, 16'h0, 1'b1, 16'h0, mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0));
    chk("reset_addr",  dmem_bus.dmem_addr,       16'h0000);
    chk("reset_wdata", dmem_bus.dmem_wdata,      16'h0000);
    chk("reset_we",    16'(dmem_bus.dmem_we),    16'h0000);

    // READ, ready on the 3rd request cycle
    clr_cnt();
    run_txn(2'b00, 16'h3000, 16'h0, 2, 0, 16'h1234, 16'h0, 1, 2);
    chk("t1_req_cycles", 16'(req_cycles), 16'd3);
    chk("t1_complete",   16'(cpl_cnt),    16'd1);
    chk("t1_memout",     memout,          16'h1234);

    // IND_READ through pointer 0x4000
    clr_cnt();
    run_txn(2'b01, 16'h3001, 16'h0, 0, 0, 16'h4000, 16'hBEEF, 1, 1);
    chk("t2_req_cycles", 16'(req_cycles), 16'd2);
    chk("t2_complete",   16'(cpl_cnt),    16'd1);
    chk("t2_memout",     memout,          16'hBEEF);

    // WRITE held afterwards: no re-execution until 11 is seen
    clr_cnt();
    run_txn(2'b10, 16'h5000, 16'hA5A5, 0, 0, 16'h0, 16'h0, 1, 3);
    chk("t3_req_cycles", 16'(req_cycles), 16'd1);
    run_txn(2'b10, 16'h5000, 16'hA5A5, 0, 0, 16'h0, 16'h0, 1, 1);
    chk("t3_rewrite",    16'(req_cycles), 16'd2);
    chk("t3_memout",     memout,          16'hBEEF);

    // ready coincides with the last allowed wait cycle
    run_txn(2'b00, 16'h0042, 16'h0, TMO - 1, 0, 16'h5A5A, 16'h0, 1, 0);
    chk("t5_mem_error",  16'(mem_error), 16'h0000);
    chk("t5_memout",     memout,         16'h5A5A);

    // timeout, memory never answers
    clr_cnt();
    run_txn(2'b00, 16'h0777, 16'h0, TMO + 1, 0, 16'hDEAD, 16'h0, 1, 0);
    chk("t4_req_cycles", 16'(req_cycles), 16'd4);
    chk("t4_mem_error",  16'(mem_error),  16'h0001);
    chk("t4_memout",     memout,          16'h5A5A);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      run_txn(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
              $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1),
              16'($urandom), 16'($urandom), $urandom_range(1, 2), $urandom_range(0, 2));
    end
    chk("rand_error_sticky", 16'(mem_error), 16'(m_err));

    // reset during IND2, released with IDLE command
    idle_cyc(2'b11);
    cyc(1'b1, 2'b01, 16'h3001, 16'h0, 1'b0, 16'h0, idle_e());
    phase(16'h3001, 1'b0, 16'h0, 0, 16'h4000, ok_tmp);
    busy_junk(idle_e());
    m_memout = 16'h0;
    m_err    = 1'b0;
    cyc(1'b0, 2'b01, 16'h0, 16'h0, 1'b1, 16'hFFFF, mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0));
    cyc(1'b0, 2'b11, 16'h0, 16'h0, 1'b0, 16'h0, mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0));
    clr_cnt();
    for (int i = 0; i < 4; i++) idle_cyc(2'b11);
    chk("t6_no_req",      16'(req_cycles), 16'd0);
    chk("t6_no_complete", 16'(cpl_cnt),    16'd0);
    chk("t6_memout",      memout,          16'h0000);

    // reset while a completed command is held: it runs again after release
    run_txn(2'b00, 16'h0100, 16'h0, 0, 0, 16'h7777, 16'h0, 1, 1);
    m_memout = 16'h0;
    m_err    = 1'b0;
    cyc(1'b0, 2'b10, 16'h6000, 16'h1111, 1'b0, 16'h0, mk(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0));
    clr_cnt();
    run_txn(2'b10, 16'h6000, 16'h1111, 0, 0, 16'h0, 16'h0, 0, 1);
    idle_cyc(2'b11);
    chk("t7_fresh_write", 16'(req_cycles), 16'd1);
    chk("t7_complete",    16'(cpl_cnt),    16'd1);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
